// File: rtl/shift_timer_pkg.sv
// rtl/shift_timer_pkg.sv - shared phase encoding and default shift counts
package shift_timer_pkg;

  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_MID  = 2'd1,
    PH_REM  = 2'd2,
    PH_DONE = 2'd3
  } phase_t;

  localparam int MID_SHIFTS_DEF   = 8;
  localparam int TOTAL_SHIFTS_DEF = 24;

endpackage

// File: rtl/phase_counter.sv
// rtl/phase_counter.sv - up-counter with sync clear and enable
module phase_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/shift_phase_timer.sv
// rtl/shift_phase_timer.sv - two-phase serial shift timer with start/abort/ack handshakes
// Optional stall watchdog enabled by SHIFT_TIMER_WATCHDOG_EN.
module shift_phase_timer
  import shift_timer_pkg::*;
#(
  parameter int MID_SHIFTS   = MID_SHIFTS_DEF,
  parameter int TOTAL_SHIFTS = TOTAL_SHIFTS_DEF,
  parameter int CNT_W        = $clog2(TOTAL_SHIFTS + 1),
  parameter int STALL_MAX    = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             shift_en,
  input  logic             abort,
  input  logic             ack,
  output logic             busy,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] count,
  output logic             midstate_shifts_done,
  output logic             remaining_shifts_done,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] MID_LAST   = CNT_W'(MID_SHIFTS - 1);
  localparam logic [CNT_W-1:0] TOTAL_LAST = CNT_W'(TOTAL_SHIFTS - 1);

  phase_t           r_phase;
  logic             r_busy;
  logic             r_mid_done;
  logic             r_rem_done;
  logic             r_timeout;
  logic             w_trip;
  logic             w_cnt_clr;
  logic             w_cnt_en;
  logic [CNT_W-1:0] w_count;

  // The count is only meaningful inside a sequence; IDLE keeps it pinned at zero.
  assign w_cnt_clr = abort || w_trip || (r_phase == PH_IDLE) || ((r_phase == PH_DONE) && ack);
  assign w_cnt_en  = shift_en && r_busy;

  phase_counter #(.W(CNT_W)) u_count (
    .clk (clk),
    .rst (rst),
    .clr (w_cnt_clr),
    .en  (w_cnt_en),
    .q   (w_count)
  );

`ifdef SHIFT_TIMER_WATCHDOG_EN
  localparam int STALL_W = $clog2(STALL_MAX + 1);
  logic [STALL_W-1:0] w_stall;

  // Trip on the idle cycle that would bring the stall count to STALL_MAX.
  assign w_trip = r_busy && !shift_en && (w_stall == STALL_W'(STALL_MAX - 1));

  phase_counter #(.W(STALL_W)) u_stall (
    .clk (clk),
    .rst (rst),
    .clr (shift_en || abort || !r_busy || w_trip),
    .en  (r_busy && !shift_en),
    .q   (w_stall)
  );

  assign timeout = r_timeout;
`else
  logic w_unused;
  assign w_trip   = 1'b0;
  assign timeout  = 1'b0;
  assign w_unused = r_timeout | (STALL_MAX > 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase    <= PH_IDLE;
      r_busy     <= 1'b0;
      r_mid_done <= 1'b0;
      r_rem_done <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_mid_done <= 1'b0;
      r_rem_done <= 1'b0;
      r_timeout  <= 1'b0;
      if (abort) begin
        r_phase <= PH_IDLE;
        r_busy  <= 1'b0;
      end else if (w_trip) begin
        r_phase   <= PH_IDLE;
        r_busy    <= 1'b0;
        r_timeout <= 1'b1;
      end else begin
        case (r_phase)
          PH_IDLE: begin
            if (start) begin
              r_phase <= PH_MID;
              r_busy  <= 1'b1;
            end
          end
          PH_MID: begin
            if (shift_en && (w_count == MID_LAST)) begin
              r_phase    <= PH_REM;
              r_mid_done <= 1'b1;
            end
          end
          PH_REM: begin
            if (shift_en && (w_count == TOTAL_LAST)) begin
              r_phase    <= PH_DONE;
              r_busy     <= 1'b0;
              r_rem_done <= 1'b1;
            end
          end
          PH_DONE: begin
            if (ack) begin
              r_phase <= PH_IDLE;
            end
          end
          default: begin
            r_phase <= PH_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy                  = r_busy;
  assign phase                 = r_phase;
  assign count                 = w_count;
  assign midstate_shifts_done  = r_mid_done;
  assign remaining_shifts_done = r_rem_done;

endmodule

// File: tb/tb_shift_phase_timer.sv
// tb/tb_shift_phase_timer.sv - randomized and directed bench with behavioural model
module tb_shift_phase_timer;

  localparam int STALL = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, shift_en = 1'b0, abort = 1'b0, ack = 1'b0;

  logic       busy_a, mp_a, rp_a, to_a;
  logic [1:0] phase_a;
  logic [4:0] count_a;
  logic       busy_b, mp_b, rp_b, to_b;
  logic [1:0] phase_b;
  logic [2:0] count_b;

  int n_checks = 0;
  int n_pass   = 0;

  int m_phase[2], m_cnt[2], m_stall[2];
  int m_mp[2], m_rp[2], m_to[2];
  int mid_n[2] = '{8, 4};
  int tot_n[2] = '{24, 5};

  always #5 clk = ~clk;

  shift_phase_timer #(.MID_SHIFTS(8), .TOTAL_SHIFTS(24), .STALL_MAX(STALL)) dut_a (
    .clk(clk), .rst(rst), .start(start), .shift_en(shift_en), .abort(abort), .ack(ack),
    .busy(busy_a), .phase(phase_a), .count(count_a),
    .midstate_shifts_done(mp_a), .remaining_shifts_done(rp_a), .timeout(to_a)
  );

  shift_phase_timer #(.MID_SHIFTS(4), .TOTAL_SHIFTS(5), .STALL_MAX(STALL)) dut_b (
    .clk(clk), .rst(rst), .start(start), .shift_en(shift_en), .abort(abort), .ack(ack),
    .busy(busy_b), .phase(phase_b), .count(count_b),
    .midstate_shifts_done(mp_b), .remaining_shifts_done(rp_b), .timeout(to_b)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_phase[k] = 0; m_cnt[k] = 0; m_stall[k] = 0;
      m_mp[k] = 0; m_rp[k] = 0; m_to[k] = 0;
    end
  endtask

  // Phases: 0 idle, 1 midstate, 2 remaining words, 3 done.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      m_mp[k] = 0; m_rp[k] = 0; m_to[k] = 0;
      if (abort) begin
        m_phase[k] = 0; m_cnt[k] = 0; m_stall[k] = 0;
      end else if (m_phase[k] == 0) begin
        if (start) m_phase[k] = 1;
      end else if (m_phase[k] == 3) begin
        if (ack) begin m_phase[k] = 0; m_cnt[k] = 0; end
      end else if (shift_en) begin
        m_stall[k] = 0;
        m_cnt[k]++;
        if (m_phase[k] == 1 && m_cnt[k] == mid_n[k]) begin m_phase[k] = 2; m_mp[k] = 1; end
        else if (m_phase[k] == 2 && m_cnt[k] == tot_n[k]) begin m_phase[k] = 3; m_rp[k] = 1; end
      end else begin
`ifdef SHIFT_TIMER_WATCHDOG_EN
        m_stall[k]++;
        if (m_stall[k] == STALL) begin
          m_phase[k] = 0; m_cnt[k] = 0; m_stall[k] = 0; m_to[k] = 1;
        end
`endif
      end
    end
  endtask

  task automatic compare_all();
    check("phase_a", phase_a, m_phase[0]);
    check("count_a", count_a, m_cnt[0]);
    check("busy_a",  busy_a,  int'(m_phase[0] == 1 || m_phase[0] == 2));
    check("midp_a",  mp_a,    m_mp[0]);
    check("remp_a",  rp_a,    m_rp[0]);
    check("tmo_a",   to_a,    m_to[0]);
    check("phase_b", phase_b, m_phase[1]);
    check("count_b", count_b, m_cnt[1]);
    check("busy_b",  busy_b,  int'(m_phase[1] == 1 || m_phase[1] == 2));
    check("midp_b",  mp_b,    m_mp[1]);
    check("remp_b",  rp_b,    m_rp[1]);
    check("tmo_b",   to_b,    m_to[1]);
  endtask

  task automatic drive(input logic st, input logic sh, input logic ab, input logic ak);
    start = st; shift_en = sh; abort = ab; ack = ak;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    model_reset();
    drive(0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    #12;
    compare_all();
    rst = 1'b0;
    drive(0, 0, 0, 0);

    // Nominal run with back-to-back shifts, ack in DONE.
    drive(1, 0, 0, 0);
    for (int i = 0; i < 24; i++) drive(0, 1, 0, 0);
    check("nominal_done", phase_a, 3);
    check("nominal_cnt", count_a, 24);
    drive(0, 1, 0, 0);
    drive(0, 0, 0, 1);
    check("after_ack_cnt", count_a, 0);

    // Alternate-cycle shift enable.
    drive(1, 0, 0, 0);
    for (int i = 0; i < 48; i++) drive(0, (i % 2) == 0, 0, 0);
    drive(0, 0, 0, 1);

    // Abort in REM at count 15, then abort on the terminal shift.
    drive(1, 0, 0, 0);
    for (int i = 0; i < 15; i++) drive(0, 1, 0, 0);
    check("pre_abort_cnt", count_a, 15);
    drive(0, 1, 1, 0);
    check("abort_idle", phase_a, 0);
    drive(1, 0, 0, 0);
    for (int i = 0; i < 23; i++) drive(0, 1, 0, 0);
    drive(0, 1, 1, 0);
    check("abort_term_pulse", rp_a, 0);

    // Ignored controls: start while busy/done, shift in IDLE, start+ack in DONE.
    drive(0, 1, 0, 0);
    drive(1, 0, 0, 0);
    drive(1, 1, 0, 0);
    for (int i = 0; i < 10; i++) drive(1, 1, 0, 0);
    for (int i = 0; i < 14; i++) drive(0, 1, 0, 0);
    drive(1, 1, 0, 0);
    drive(1, 0, 0, 1);
    check("start_ack_idle", phase_a, 0);

    // Stall in MID at count 3.
    drive(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 1, 0, 0);
    for (int i = 0; i < 6; i++) drive(0, 0, 0, 0);
    drive(0, 0, 1, 0);

    // Asynchronous reset mid-cycle at count 10.
    drive(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) drive(0, 1, 0, 0);
    check("pre_rst_cnt", count_a, 10);
    #2 rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    rst = 1'b0;
    do_reset();

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 99) == 0, $urandom_range(0, 4) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
